// File: rtl/cpu_axi_pkg.sv
// Shared definitions for the CPU-to-AXI3 bridge: FSM states, AXI IDs,
// burst type and the sram size to AXI size mapping.
package cpu_axi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_AR   = 3'd1,
    ST_R    = 3'd2,
    ST_W    = 3'd3,
    ST_B    = 3'd4
  } state_t;

  localparam logic [3:0] ID_INST    = 4'd0;
  localparam logic [3:0] ID_DATA    = 4'd1;
  localparam logic [1:0] BURST_INCR = 2'b01;

  // sram size code (0 byte, 1 half, 2 word) maps directly onto AXI AxSIZE
  function automatic logic [2:0] size_to_axsize(input logic [1:0] size);
    return {1'b0, size};
  endfunction

endpackage

// File: rtl/cpu_axi_bridge.sv
// Bridges the core's fetch and data sram-like ports onto one AXI3 master.
// One transaction outstanding at a time; data port wins arbitration.
module cpu_axi_bridge
  import cpu_axi_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  // instruction fetch port
  input  logic        inst_req,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  // data port
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  // AXI read address
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic        arvalid,
  input  logic        arready,
  // AXI read data
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  // AXI write address
  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [7:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic        awvalid,
  input  logic        awready,
  // AXI write data
  output logic [3:0]  wid,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  // AXI write response
  input  logic [3:0]  bid,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready
);

  state_t      r_state;
  state_t      w_state_next;

  logic        r_owner_data;
  logic        r_wr;
  logic [1:0]  r_size;
  logic [31:0] r_addr;
  logic [3:0]  r_wstrb;
  logic [31:0] r_wdata;
  logic        r_aw_done;
  logic        r_w_done;
  logic [31:0] r_inst_rdata;
  logic [31:0] r_data_rdata;
  logic        r_inst_ok;
  logic        r_data_ok;

  logic        w_idle;
  logic        w_grant_data;
  logic        w_grant_inst;
  logic        w_accept;
  logic        w_r_done;
  logic        w_b_done;

  // IDs, responses and single-beat read ends are not used: only one
  // transaction is ever in flight, so the owner register routes the reply.
  logic        w_unused_axi;
  assign w_unused_axi = ^{rid, rresp, rlast, bid, bresp, r_wr};

  // Arbitration is a pure function of the current request lines in IDLE
  assign w_idle       = (r_state == ST_IDLE);
  assign w_grant_data = w_idle && data_req;
  assign w_grant_inst = w_idle && inst_req && !data_req;
  assign w_accept     = w_grant_data || w_grant_inst;
  assign data_addr_ok = w_grant_data;
  assign inst_addr_ok = w_grant_inst;

  assign w_r_done = (r_state == ST_R) && rvalid;
  assign w_b_done = (r_state == ST_B) && bvalid;

  // Address/data channel payloads come straight from the latched request
  assign arid    = r_owner_data ? ID_DATA : ID_INST;
  assign araddr  = r_addr;
  assign arlen   = 8'd0;
  assign arsize  = size_to_axsize(r_size);
  assign arburst = BURST_INCR;
  assign awid    = ID_DATA;
  assign awaddr  = r_addr;
  assign awlen   = 8'd0;
  assign awsize  = size_to_axsize(r_size);
  assign awburst = BURST_INCR;
  assign wid     = ID_DATA;
  assign wdata   = r_wdata;
  assign wstrb   = r_wstrb;
  assign wlast   = 1'b1;

  assign inst_rdata   = r_inst_rdata;
  assign data_rdata   = r_data_rdata;
  assign inst_data_ok = r_inst_ok;
  assign data_data_ok = r_data_ok;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic and AXI valid/ready outputs
  always_comb begin
    w_state_next = r_state;
    arvalid      = 1'b0;
    rready       = 1'b0;
    awvalid      = 1'b0;
    wvalid       = 1'b0;
    bready       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_grant_data) begin
          w_state_next = data_wr ? ST_W : ST_AR;
        end else if (w_grant_inst) begin
          w_state_next = ST_AR;
        end
      end
      ST_AR: begin
        arvalid = 1'b1;
        if (arready) w_state_next = ST_R;
      end
      ST_R: begin
        rready = 1'b1;
        if (rvalid) w_state_next = ST_IDLE;
      end
      ST_W: begin
        awvalid = !r_aw_done;
        wvalid  = !r_w_done;
        if ((r_aw_done || awready) && (r_w_done || wready)) w_state_next = ST_B;
      end
      ST_B: begin
        bready = 1'b1;
        if (bvalid) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Request capture, write-handshake tracking and response registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_owner_data <= 1'b0;
      r_wr         <= 1'b0;
      r_size       <= 2'd0;
      r_addr       <= 32'd0;
      r_wstrb      <= 4'd0;
      r_wdata      <= 32'd0;
      r_aw_done    <= 1'b0;
      r_w_done     <= 1'b0;
      r_inst_rdata <= 32'd0;
      r_data_rdata <= 32'd0;
      r_inst_ok    <= 1'b0;
      r_data_ok    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_owner_data <= w_grant_data;
        r_wr         <= w_grant_data && data_wr;
        r_size       <= w_grant_data ? data_size : inst_size;
        r_addr       <= w_grant_data ? data_addr : inst_addr;
        r_wstrb      <= w_grant_data ? data_wstrb : 4'd0;
        r_wdata      <= w_grant_data ? data_wdata : 32'd0;
      end
      // done flags live only while we stay in W; they clear on leaving it
      r_aw_done <= (r_state == ST_W) && (w_state_next == ST_W) && (r_aw_done || awready);
      r_w_done  <= (r_state == ST_W) && (w_state_next == ST_W) && (r_w_done || wready);
      if (w_r_done && !r_owner_data) r_inst_rdata <= rdata;
      if (w_r_done && r_owner_data)  r_data_rdata <= rdata;
      r_inst_ok <= w_r_done && !r_owner_data;
      r_data_ok <= (w_r_done && r_owner_data) || w_b_done;
    end
  end

endmodule

// File: tb/tb_cpu_axi_bridge.sv
// Testbench for cpu_axi_bridge: random core traffic on both ports against
// an AXI slave with random delays; a memory model predicts every response.
module tb_cpu_axi_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_req, inst_addr_ok, inst_data_ok;
  logic [1:0]  inst_size;
  logic [31:0] inst_addr, inst_rdata;
  logic        data_req, data_wr, data_addr_ok, data_data_ok;
  logic [1:0]  data_size;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic [3:0]  arid, rid, awid, wid, bid, wstrb;
  logic [31:0] araddr, rdata, awaddr, wdata;
  logic [7:0]  arlen, awlen;
  logic [2:0]  arsize, awsize;
  logic [1:0]  arburst, rresp, awburst, bresp;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;

  always #5 clk = ~clk;

  cpu_axi_bridge dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_size(inst_size), .inst_addr(inst_addr),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  typedef struct packed {
    logic        is_data;
    logic        wr;
    logic [31:0] addr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } txn_t;

  txn_t        exp_q[$];   // responses the core ports must see, in order
  txn_t        axi_q[$];   // AXI transactions the slave must see, in order
  logic [31:0] model_mem [logic [31:0]];
  logic [31:0] slave_mem [logic [31:0]];
  logic [31:0] last_inst, last_data;

  int errors = 0;
  int checks = 0;
  int n_txn  = 0;
  bit chk_en = 0;
  bit r_hang = 0;
  bit r_abort = 0;
  int ar_fix = -1, r_fix = -1, aw_fix = -1, w_fix = -1, b_fix = -1;
  localparam int TMO = 2000;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, required 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, required %b at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h0BADF00D;
  endfunction

  function automatic logic [31:0] model_rd(input logic [31:0] a);
    logic [31:0] wa;
    wa = {a[31:2], 2'b00};
    return model_mem.exists(wa) ? model_mem[wa] : init_word(wa);
  endfunction

  function automatic void model_wr(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
    logic [31:0] v;
    v = model_rd(a);
    for (int b = 0; b < 4; b++) if (be[b]) v[8*b +: 8] = d[8*b +: 8];
    model_mem[{a[31:2], 2'b00}] = v;
  endfunction

  function automatic logic [31:0] slave_rd(input logic [31:0] a);
    logic [31:0] wa;
    wa = {a[31:2], 2'b00};
    return slave_mem.exists(wa) ? slave_mem[wa] : init_word(wa);
  endfunction

  function automatic void slave_wr(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
    logic [31:0] v;
    v = slave_rd(a);
    for (int b = 0; b < 4; b++) if (be[b]) v[8*b +: 8] = d[8*b +: 8];
    slave_mem[{a[31:2], 2'b00}] = v;
  endfunction

  function automatic int pick(input int fix, input int mx);
    return (fix >= 0) ? fix : int'($urandom_range(mx, 0));
  endfunction

  // ---------------- acceptance: predict addr_ok and record the request
  always begin : accept_p
    txn_t t;
    logic busy, exp_d, exp_i;
    @(negedge clk);
    #2;
    if (chk_en) begin
      busy  = (exp_q.size() != 0);
      exp_d = !busy && data_req;
      exp_i = !busy && inst_req && !data_req;
      check1("data_addr_ok", data_addr_ok, exp_d);
      check1("inst_addr_ok", inst_addr_ok, exp_i);
      if (data_addr_ok) begin
        t.is_data = 1'b1; t.wr = data_wr; t.addr = data_addr; t.size = data_size;
        t.wstrb = data_wstrb; t.wdata = data_wdata;
        if (data_wr) begin
          model_wr(data_addr, data_wstrb, data_wdata);
          t.rdata = 32'd0;
        end else begin
          t.rdata = model_rd(data_addr);
        end
        exp_q.push_back(t);
        axi_q.push_back(t);
      end else if (inst_addr_ok) begin
        t.is_data = 1'b0; t.wr = 1'b0; t.addr = inst_addr; t.size = inst_size;
        t.wstrb = 4'd0; t.wdata = 32'd0; t.rdata = model_rd(inst_addr);
        exp_q.push_back(t);
        axi_q.push_back(t);
      end
    end
  end

  // ---------------- monitor: pop and compare whenever a data_ok appears
  always begin : monitor_p
    txn_t t;
    @(negedge clk);
    #1;
    if (chk_en) begin
      check1("ok_exclusive", inst_data_ok && data_data_ok, 1'b0);
      if (inst_data_ok) begin
        if (exp_q.size() == 0) begin
          check1("unexpected_inst_data_ok", inst_data_ok, 1'b0);
        end else begin
          t = exp_q.pop_front();
          n_txn++;
          check1("inst_ok_owner", t.is_data, 1'b0);
          check32("inst_rdata", inst_rdata, t.rdata);
          if (!t.is_data) last_inst = t.rdata;
          $display("txn %0d: inst read  addr=0x%08h rdata=0x%08h", n_txn, t.addr, inst_rdata);
        end
      end else begin
        check32("inst_rdata_hold", inst_rdata, last_inst);
      end
      if (data_data_ok) begin
        if (exp_q.size() == 0) begin
          check1("unexpected_data_data_ok", data_data_ok, 1'b0);
        end else begin
          t = exp_q.pop_front();
          n_txn++;
          check1("data_ok_owner", t.is_data, 1'b1);
          if (t.wr) begin
            check32("data_rdata_hold_wr", data_rdata, last_data);
            $display("txn %0d: data write addr=0x%08h wdata=0x%08h wstrb=%b", n_txn, t.addr, t.wdata, t.wstrb);
          end else begin
            check32("data_rdata", data_rdata, t.rdata);
            if (t.is_data) last_data = t.rdata;
            $display("txn %0d: data read  addr=0x%08h rdata=0x%08h", n_txn, t.addr, data_rdata);
          end
        end
      end else begin
        check32("data_rdata_hold", data_rdata, last_data);
      end
    end
  end

  // ---------------- AXI slave
  task automatic slave_read();
    txn_t t;
    logic [31:0] a0;
    logic [3:0]  id0;
    int d;
    check1("ar_expected", axi_q.size() != 0, 1'b1);
    t = (axi_q.size() != 0) ? axi_q.pop_front() : '0;
    check1("ar_not_write", t.wr, 1'b0);
    check32("arid", 32'(arid), t.is_data ? 32'd1 : 32'd0);
    check32("araddr", araddr, t.addr);
    check32("arsize", 32'(arsize), 32'(t.size));
    check32("arlen", 32'(arlen), 32'd0);
    check32("arburst", 32'(arburst), 32'd1);
    a0 = araddr;
    id0 = arid;
    d = pick(ar_fix, 3);
    repeat (d) begin
      @(negedge clk);
      check1("arvalid_held", arvalid, 1'b1);
      check32("araddr_stable", araddr, a0);
      check32("arid_stable", 32'(arid), 32'(id0));
      check1("no_addr_ok_in_ar", inst_addr_ok || data_addr_ok, 1'b0);
    end
    arready = 1'b1;
    @(negedge clk);
    arready = 1'b0;
    check1("arvalid_drop", arvalid, 1'b0);
    while (r_hang) @(negedge clk);
    if (r_abort) return;
    d = pick(r_fix, 3);
    repeat (d) @(negedge clk);
    check1("rready_in_r", rready, 1'b1);
    rvalid = 1'b1;
    rlast  = 1'b1;
    rid    = id0;
    rresp  = 2'($urandom_range(3, 0));
    rdata  = slave_rd(a0);
    @(negedge clk);
    rvalid = 1'b0;
    rdata  = $urandom;
  endtask

  task automatic slave_write();
    txn_t t;
    logic [31:0] a0, d0;
    logic [3:0]  s0;
    int da, dw, db, c;
    bit aw_done, w_done;
    check1("aw_expected", axi_q.size() != 0, 1'b1);
    t = (axi_q.size() != 0) ? axi_q.pop_front() : '0;
    check1("aw_is_write", t.wr, 1'b1);
    check32("awid", 32'(awid), 32'd1);
    check32("wid", 32'(wid), 32'd1);
    check32("awaddr", awaddr, t.addr);
    check32("awsize", 32'(awsize), 32'(t.size));
    check32("awlen", 32'(awlen), 32'd0);
    check32("awburst", 32'(awburst), 32'd1);
    check32("wdata", wdata, t.wdata);
    check32("wstrb", 32'(wstrb), 32'(t.wstrb));
    check1("wlast", wlast, 1'b1);
    a0 = awaddr; d0 = wdata; s0 = wstrb;
    da = pick(aw_fix, 3);
    dw = pick(w_fix, 3);
    aw_done = 0; w_done = 0; c = 0;
    while (!(aw_done && w_done)) begin
      check1("awvalid_level", awvalid, !aw_done);
      check1("wvalid_level", wvalid, !w_done);
      check1("bready_low_in_w", bready, 1'b0);
      awready = !aw_done && (c >= da);
      wready  = !w_done && (c >= dw);
      @(negedge clk);
      if (awready) aw_done = 1;
      if (wready)  w_done = 1;
      awready = 1'b0;
      wready  = 1'b0;
      c++;
    end
    slave_wr(a0, s0, d0);
    check1("awvalid_after_w", awvalid, 1'b0);
    check1("wvalid_after_w", wvalid, 1'b0);
    db = pick(b_fix, 3);
    repeat (db) @(negedge clk);
    check1("bready_in_b", bready, 1'b1);
    bvalid = 1'b1;
    bid    = 4'd1;
    bresp  = 2'($urandom_range(3, 0));
    @(negedge clk);
    bvalid = 1'b0;
  endtask

  initial begin : slave_p
    arready = 0; rvalid = 0; rid = 0; rdata = 0; rresp = 0; rlast = 0;
    awready = 0; wready = 0; bvalid = 0; bid = 0; bresp = 0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (arvalid) slave_read();
        else if (awvalid || wvalid) slave_write();
      end
    end
  end

  // ---------------- core-side drivers
  task automatic inst_issue(input logic [31:0] a, input logic [1:0] s);
    bit got;
    got = 0;
    inst_addr = a; inst_size = s; inst_req = 1'b1;
    for (int c = 0; c < TMO; c++) begin
      #3;
      if (inst_addr_ok) begin got = 1; break; end
      @(negedge clk);
    end
    if (!got) check1("inst_accept_timeout", got, 1'b1);
    @(negedge clk);
    inst_req = 1'b0;
  endtask

  task automatic data_issue(input logic wr, input logic [31:0] a, input logic [1:0] s,
                            input logic [3:0] be, input logic [31:0] d);
    bit got;
    got = 0;
    data_wr = wr; data_addr = a; data_size = s; data_wstrb = be; data_wdata = d;
    data_req = 1'b1;
    for (int c = 0; c < TMO; c++) begin
      #3;
      if (data_addr_ok) begin got = 1; break; end
      @(negedge clk);
    end
    if (!got) check1("data_accept_timeout", got, 1'b1);
    @(negedge clk);
    data_req = 1'b0;
  endtask

  task automatic drain();
    int c;
    c = 0;
    while (exp_q.size() != 0 && c < 1000) begin
      @(negedge clk);
      c++;
    end
    check32("drain_pending", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check1({tag, "_arvalid"}, arvalid, 1'b0);
    check1({tag, "_rready"}, rready, 1'b0);
    check1({tag, "_awvalid"}, awvalid, 1'b0);
    check1({tag, "_wvalid"}, wvalid, 1'b0);
    check1({tag, "_bready"}, bready, 1'b0);
    check1({tag, "_inst_addr_ok"}, inst_addr_ok, 1'b0);
    check1({tag, "_data_addr_ok"}, data_addr_ok, 1'b0);
    check1({tag, "_inst_data_ok"}, inst_data_ok, 1'b0);
    check1({tag, "_data_data_ok"}, data_data_ok, 1'b0);
    check32({tag, "_inst_rdata"}, inst_rdata, 32'd0);
    check32({tag, "_data_rdata"}, data_rdata, 32'd0);
    check32({tag, "_araddr"}, araddr, 32'd0);
    check32({tag, "_awaddr"}, awaddr, 32'd0);
    check32({tag, "_wdata"}, wdata, 32'd0);
    check32({tag, "_wstrb"}, 32'(wstrb), 32'd0);
  endtask

  // ---------------- main sequence
  initial begin : main_p
    int c;
    reset = 1'b1;
    inst_req = 0; inst_size = 0; inst_addr = 0;
    data_req = 0; data_wr = 0; data_size = 0; data_wstrb = 0; data_addr = 0; data_wdata = 0;
    last_inst = 0; last_data = 0;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    reset = 1'b0;
    chk_en = 1;
    @(negedge clk);

    // single fetch, one cycle of arready delay
    model_mem[32'h1c000000] = 32'h12345678;
    slave_mem[32'h1c000000] = 32'h12345678;
    ar_fix = 1; r_fix = 0;
    inst_issue(32'h1c000000, 2'd2);
    drain();
    check32("fetch_rdata_final", inst_rdata, 32'h12345678);

    // simultaneous requests: data read wins, inst accepted in data_ok cycle
    ar_fix = 0; r_fix = 0;
    fork
      inst_issue(32'h1c000004, 2'd2);
      data_issue(1'b0, 32'h80, 2'd2, 4'hf, 32'd0);
    join
    drain();

    // write with split handshakes, then read the merged word back
    aw_fix = 0; w_fix = 2; b_fix = 0;
    data_issue(1'b1, 32'h84, 2'd2, 4'b0011, 32'hAABBCCDD);
    data_issue(1'b0, 32'h84, 2'd2, 4'hf, 32'd0);
    drain();

    // arready held low five cycles while an inst request waits
    ar_fix = 5;
    fork
      data_issue(1'b0, 32'h88, 2'd1, 4'hf, 32'd0);
      begin
        @(negedge clk);
        inst_issue(32'h1c000008, 2'd2);
      end
    join
    drain();

    // random traffic on both ports
    ar_fix = -1; r_fix = -1; aw_fix = -1; w_fix = -1; b_fix = -1;
    fork
      begin
        for (int i = 0; i < 50; i++) begin
          repeat ($urandom_range(3, 0)) @(negedge clk);
          inst_issue(32'h80 + 32'($urandom_range(15, 0)) * 4, 2'd2);
        end
      end
      begin
        for (int i = 0; i < 60; i++) begin
          repeat ($urandom_range(6, 0)) @(negedge clk);
          data_issue(1'($urandom_range(1, 0)), 32'h80 + 32'($urandom_range(15, 0)) * 4,
                     2'($urandom_range(2, 0)), 4'($urandom_range(15, 0)), $urandom);
        end
      end
    join
    drain();

    // asynchronous reset while waiting for read data
    ar_fix = 0; r_fix = 0;
    r_hang = 1;
    data_issue(1'b0, 32'h90, 2'd2, 4'hf, 32'd0);
    c = 0;
    while (!rready && c < 20) begin
      @(negedge clk);
      c++;
    end
    check1("reached_r_state", rready, 1'b1);
    chk_en = 0;
    #3;
    reset = 1'b1;
    #1;
    check_reset_outputs("async");
    exp_q.delete();
    axi_q.delete();
    last_inst = 0;
    last_data = 0;
    r_abort = 1;
    r_hang = 0;
    @(negedge clk);
    reset = 1'b0;
    chk_en = 1;
    repeat (6) @(negedge clk);
    r_abort = 0;
    model_mem[32'h1c00000c] = 32'hCAFEF00D;
    slave_mem[32'h1c00000c] = 32'hCAFEF00D;
    inst_issue(32'h1c00000c, 2'd2);
    drain();
    check32("post_reset_fetch", inst_rdata, 32'hCAFEF00D);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cpu_axi_bridge.md
# cpu_axi_bridge

Converts the core's two sram-like request/response ports (instruction fetch, data access) into one AXI3 master port. It sits directly downstream of the CPU core top, replacing its fixed-latency SRAM interfaces. The bridge arbitrates between the two ports, keeps at most one AXI transaction outstanding, and returns each response to the port that issued the request.

## Interface
Parameters: none. Address and data are fixed at 32 bits. AXI ID width is 4.

Ports (signal, direction, width, meaning):
- clk  in  1  single clock; all logic on posedge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- inst_req  in  1  fetch request valid (read only).
- inst_size  in  2  0 = byte, 1 = half, 2 = word.
- inst_addr  in  32  fetch address.
- inst_addr_ok  out  1  fetch request accepted this cycle.
- inst_data_ok  out  1  fetch data valid (one-cycle pulse).
- inst_rdata  out  32  fetch data.
- data_req  in  1  data request valid.
- data_wr  in  1  1 = write, 0 = read.
- data_size  in  2  encoded as inst_size.
- data_wstrb  in  4  byte enables for writes.
- data_addr  in  32  data address.
- data_wdata  in  32  data to write.
- data_addr_ok  out  1  data request accepted this cycle.
- data_data_ok  out  1  read data valid, or write complete (one-cycle pulse).
- data_rdata  out  32  read data.
- AXI read address: arid out 4, araddr out 32, arlen out 8, arsize out 3, arburst out 2, arvalid out 1, arready in 1.
- AXI read data: rid in 4, rdata in 32, rresp in 2, rlast in 1, rvalid in 1, rready out 1.
- AXI write address: awid out 4, awaddr out 32, awlen out 8, awsize out 3, awburst out 2, awvalid out 1, awready in 1.
- AXI write data: wid out 4, wdata out 32, wstrb out 4, wlast out 1, wvalid out 1, wready in 1.
- AXI write response: bid in 4, bresp in 2, bvalid in 1, bready out 1.
- The AXI lock/cache/prot signals are constants tied off at the top level and are not part of this block.

## Operation
- The FSM has states IDLE, AR, R, W, B. Reset state is IDLE.
- Arbitration: only in IDLE. If data_req and inst_req are both high, data wins.
- addr_ok is combinational. It equals state==IDLE && req && granted, and it is never asserted outside IDLE.
- On acceptance, the bridge latches owner (inst/data), wr, size, addr, wstrb and wdata.
  - A read goes to AR.
  - A write goes to W.
- AR state:
  - Drive arvalid=1 with araddr=latched addr, arsize={1'b0,size}, arlen=0, arburst=2'b01.
  - arid is 0 for inst and 1 for data.
  - Hold all AR signals stable until arready. On arvalid&&arready, go to R.
- R state:
  - rready=1.
  - On rvalid (rlast is assumed 1 because arlen=0), latch rdata into the owner's rdata register, pulse the owner's data_ok on the next cycle, and return to IDLE.
  - rresp and rid are ignored.
- W state:
  - Drive awvalid=1 and wvalid=1 together, with awid=wid=1, awlen=0, wlast=1, awburst=2'b01.
  - Each valid drops independently after its own handshake.
  - When both handshakes are done (in the same or different cycles), go to B.
- B state:
  - bready=1.
  - On bvalid, pulse data_data_ok on the next cycle and return to IDLE. bresp is ignored.
- inst_rdata and data_rdata hold their last value until the next response for that port.
- All AXI valids and readies are 0 in IDLE.

## Timing
- Reset values: all valids/readies 0, addr_ok 0, data_ok 0, rdata 0, araddr/awaddr/wdata/wstrb 0, FSM IDLE.
- Minimum read latency: addr_ok at cycle 0; arvalid from cycle 1; arready at cycle 1; rvalid at cycle 2; data_ok at cycle 3.
- Minimum write latency: addr_ok at cycle 0; aw/w handshakes at cycle 1; bvalid at cycle 2; data_data_ok at cycle 3.
- The FSM is back in IDLE in the same cycle that data_ok is high. A new request can therefore be accepted (addr_ok) in the data_ok cycle, giving back-to-back transactions every 3 cycles at best.
- A starved inst_req is held by the core. The bridge gives no fairness guarantee beyond returning to IDLE after every transaction.
- Asynchronous reset in any state:
  - Immediate return to IDLE with all outputs at reset values.
  - The outstanding transaction is dropped and no data_ok is issued.
  - The core and the slave are reset in the same domain.

## Structure
- Shared package (`cpu_axi_pkg`) holds:
  - FSM state encoding.
  - ID_INST=4'd0 and ID_DATA=4'd1.
  - BURST_INCR=2'b01.
  - The size-to-arsize mapping.
- A single flat module. No sub-module is warranted, because the arbiter is two gates and the response registers are trivial.

## Test plan
- Single fetch: inst_req, addr 0x1c000000, size 2; the slave returns 0x12345678 with one cycle of ready delay. Required: arid=0, arsize=2, then one inst_data_ok pulse with inst_rdata=0x12345678.
- Simultaneous requests: inst_req and data_req (read 0x80) in the same cycle. Required: data_addr_ok=1 and inst_addr_ok=0. The data read completes first, then the inst read is accepted in the cycle data_data_ok pulses.
- Write with split handshakes: wstrb 4'b0011, wdata 0xAABBCCDD. awready arrives at cycle 1 and wready at cycle 3. Required: awvalid drops after cycle 1, wvalid stays high until cycle 3, bready is high only in B, and one data_data_ok pulse follows bvalid.
- Back-pressure stability: arready is held low for 5 cycles. Required: arvalid, araddr and arid stay stable, and no addr_ok is asserted during that time.
- Asynchronous reset asserted while in R: required is that all outputs go to 0 immediately and no data_ok is issued after reset release. The first request after reset is then accepted in IDLE.
